// File: rtl/dsc_op_sequencer.sv
// dsc_op_sequencer: accepts one operand set, runs the stochastic core until it finishes,
// hits the cycle budget or saturates its counter, then presents the captured result.
module dsc_op_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 2,
  parameter int CYC_WIDTH  = NUM_INPUTS*DATA_WIDTH+1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic                             limit_en,
  input  logic [CYC_WIDTH-1:0]             cycle_limit,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data,
  output logic                             core_en,
  output logic                             core_rst,
  input  logic                             core_op_finished,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] core_bin_data_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_data,
  output logic [CYC_WIDTH-1:0]             out_cycles,
  output logic                             out_truncated,
  output logic                             out_overflow
);
  localparam logic [CYC_WIDTH-1:0] ONE = CYC_WIDTH'(1);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, OUT} state_t;
  state_t r_state, w_next;
  logic [CYC_WIDTH-1:0] r_cnt, r_limit, w_cnt_inc;
  logic r_limit_en, w_accept, w_fin, w_lim, w_sat, w_done;
  assign in_ready  = rst && r_state == IDLE;
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = r_cnt + ONE;
  assign w_fin     = core_op_finished;
  assign w_lim     = r_limit_en && r_limit != '0 && w_cnt_inc == r_limit;
  assign w_sat     = &w_cnt_inc;
  assign w_done    = w_fin || w_lim || w_sat;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? CLEAR : IDLE;
      CLEAR:   w_next = RUN;
      RUN:     w_next = w_done ? CAPTURE : RUN;
      CAPTURE: w_next = OUT;
      OUT:     w_next = out_ready ? IDLE : OUT;
      default: w_next = IDLE;
    endcase
  end
  // core_en/core_rst are decoded from the next state so they change cleanly on the state edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_limit       <= '0;
      r_limit_en    <= 1'b0;
      core_data     <= '0;
      core_en       <= 1'b0;
      core_rst      <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_cycles    <= '0;
      out_truncated <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      r_state  <= w_next;
      core_en  <= w_next == RUN;
      core_rst <= w_next == IDLE || w_next == CLEAR;
      if (w_accept) begin
        core_data  <= in_data;
        r_limit_en <= limit_en;
        r_limit    <= cycle_limit;
        r_cnt      <= '0;
      end
      if (r_state == RUN && w_done) begin
        out_cycles    <= w_cnt_inc;
        out_truncated <= !w_fin;
        out_overflow  <= w_sat && !w_fin && !w_lim;
      end else if (r_state == RUN) begin
        r_cnt <= w_cnt_inc;
      end
      if (r_state == CAPTURE) begin
        out_data  <= core_bin_data_out;
        out_valid <= 1'b1;
      end
      if (r_state == OUT && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dsc_op_sequencer.sv
// tb_dsc_op_sequencer: vector table, random operations against a budget/finish model,
// and hand-written backpressure, mid-run reset and counter saturation sequences.
module tb_dsc_op_sequencer;
  localparam int MAXC = (1 << 17) - 1;
  logic clk = 0, rst = 0, in_valid = 0, limit_en = 0, out_ready = 0;
  logic [15:0] in_data = '0, result = '0;
  logic [16:0] cycle_limit = '0;
  logic in_ready, core_en, core_rst, core_op_finished, out_valid, out_truncated, out_overflow;
  logic [15:0] core_data, out_data;
  logic [16:0] out_cycles;
  logic d2_in_ready, d2_en, d2_rst, d2_valid, d2_trunc, d2_ovf;
  logic [15:0] d2_core_data, d2_data;
  logic [3:0] d2_cycles;
  int fin_at = 0, en_cnt = 0, errors = 0, checks = 0;

  always #5 clk = ~clk;

  dsc_op_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .limit_en(limit_en), .cycle_limit(cycle_limit), .core_data(core_data), .core_en(core_en),
    .core_rst(core_rst), .core_op_finished(core_op_finished), .core_bin_data_out(result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cycles(out_cycles),
    .out_truncated(out_truncated), .out_overflow(out_overflow));

  dsc_op_sequencer #(.CYC_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
    .limit_en(limit_en), .cycle_limit(cycle_limit[3:0]), .core_data(d2_core_data), .core_en(d2_en),
    .core_rst(d2_rst), .core_op_finished(core_op_finished), .core_bin_data_out(result),
    .out_valid(d2_valid), .out_ready(out_ready), .out_data(d2_data), .out_cycles(d2_cycles),
    .out_truncated(d2_trunc), .out_overflow(d2_ovf));

  // core model: counts enabled cycles since its reset and finishes on cycle fin_at
  always @(posedge clk)
    if (core_rst) en_cnt <= 0;
    else if (core_en) en_cnt <= en_cnt + 1;
  assign core_op_finished = core_en && fin_at != 0 && en_cnt + 1 == fin_at;

  typedef struct {
    logic [15:0] data; bit le; int lim; int fin; logic [15:0] res;
    int n; bit tr; bit ov; int hold;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // operation length is the earliest of finish, budget and saturation; finish wins ties
  function automatic void model(input int fin, input bit le, input int lim,
                                output int n, output bit tr, output bit ov);
    n = MAXC;
    if (le && lim != 0 && lim < n) n = lim;
    if (fin != 0 && fin <= n) n = fin;
    tr = !(fin != 0 && fin == n);
    ov = n == MAXC && tr && !(le && lim == MAXC);
  endfunction

  task automatic run_op(input vec_t v);
    int k, lat;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_data = v.data; limit_en = v.le; cycle_limit = 17'(v.lim);
    fin_at = v.fin; result = v.res;
    @(negedge clk);
    in_valid = 0;
    chk("in_ready_clear", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 1000) begin @(negedge clk); lat++; end
    chk("latency", lat, v.n + 3);
    chk("out_cycles", out_cycles, v.n);
    chk("out_truncated", out_truncated, v.tr);
    chk("out_overflow", out_overflow, v.ov);
    chk("out_data", out_data, v.res);
    chk("core_en_cycles", en_cnt, v.n);
    chk("core_data", core_data, v.data);
    chk("core_en_off", core_en, 0);
    for (int i = 0; i < v.hold; i++) begin
      in_valid = (i == 1); in_data = ~v.data;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, v.res);
      chk("hold_cycles", out_cycles, v.n);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
    chk("no_accept", core_data, v.data);
  endtask

  task automatic sat_op(input bit le);
    int k;
    rst = 0; @(negedge clk); rst = 1;
    in_valid = 1; limit_en = le; cycle_limit = '0; fin_at = 0; in_data = 16'h0f0f;
    @(negedge clk);
    in_valid = 0; k = 0;
    while (!d2_valid && k < 100) begin @(negedge clk); k++; end
    chk("sat_cycles", d2_cycles, 15);
    chk("sat_truncated", d2_trunc, 1);
    chk("sat_overflow", d2_ovf, 1);
    chk("sat_latency", k + 1, 18);
  endtask

  vec_t tbl[8];
  vec_t v;

  initial begin
    tbl[0] = '{16'h0503, 0, 0, 20, 16'd15, 20, 0, 0, 0};
    tbl[1] = '{16'h0102, 1, 10, 0, 16'h00aa, 10, 1, 0, 0};
    tbl[2] = '{16'h0304, 1, 10, 10, 16'h0055, 10, 0, 0, 0};
    tbl[3] = '{16'h0607, 1, 1, 0, 16'h1111, 1, 1, 0, 0};
    tbl[4] = '{16'h0809, 0, 5, 1, 16'h2222, 1, 0, 0, 0};
    tbl[5] = '{16'h0a0b, 1, 12, 7, 16'h3333, 7, 0, 0, 0};
    tbl[6] = '{16'h0c0d, 1, 7, 12, 16'h4444, 7, 1, 0, 0};
    tbl[7] = '{16'h0e0f, 0, 0, 9, 16'h5555, 9, 0, 0, 5};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_out_cycles", out_cycles, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_op(tbl[i]);
    for (int i = 0; i < 20; i++) begin
      v.data = 16'($urandom); v.res = 16'($urandom); v.le = 1'($urandom);
      v.lim = $urandom_range(0, 40); v.fin = $urandom_range(0, 40);
      if (v.fin == 0 && !(v.le && v.lim != 0)) v.fin = $urandom_range(1, 40);
      v.hold = $urandom_range(0, 3);
      model(v.fin, v.le, v.lim, v.n, v.tr, v.ov);
      run_op(v);
    end
    begin
      int k;
      in_valid = 1; in_data = 16'h1234; limit_en = 0; cycle_limit = '0; fin_at = 0;
      @(negedge clk);
      in_valid = 0; k = 0;
      while (!(core_en && en_cnt == 6) && k < 50) begin @(negedge clk); k++; end
      chk("rst_mid_reach", en_cnt, 6);
      rst = 0; #1;
      chk("rst_mid_in_ready", in_ready, 0);
      @(negedge clk);
      chk("rst_mid_core_en", core_en, 0);
      chk("rst_mid_core_rst", core_rst, 1);
      chk("rst_mid_out_valid", out_valid, 0);
      rst = 1; #1;
      chk("rst_mid_ready_back", in_ready, 1);
      run_op('{16'h0a0b, 1, 5, 0, 16'h0077, 5, 1, 0, 0});
    end
    sat_op(0);
    sat_op(1);
    rst = 0; @(negedge clk); rst = 1; @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dsc_op_sequencer.md
Name: dsc_op_sequencer

Overview:
- Upstream control stage for the stochastic-computing `core` multiplier.
- Accepts one operand set per operation over a valid/ready handshake and drives the core's operands, `en` and `rst`.
- Counts core cycles and ends the operation on `op_finished`, on a programmable cycle budget, or on counter saturation.
- Presents the captured `bin_data_out`, the cycle count and the termination flags over a valid/ready output handshake.

Parameters:
- DATA_WIDTH, 8: width of one operand.
- NUM_INPUTS, 2: number of operands per operation.
- CYC_WIDTH, NUM_INPUTS*DATA_WIDTH+1: width of the cycle counter, the budget and the reported count.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-low reset.
- in_valid, input, 1: operand set valid.
- in_ready, output, 1: sequencer can accept an operand set.
- in_data, input, NUM_INPUTS*DATA_WIDTH: packed operands, operand i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- limit_en, input, 1: enable cycle budget; sampled at accept.
- cycle_limit, input, CYC_WIDTH: cycle budget; sampled at accept; 0 means no budget.
- core_data, output, NUM_INPUTS*DATA_WIDTH: latched operands driven to the core.
- core_en, output, 1: core enable.
- core_rst, output, 1: core reset, active-high.
- core_op_finished, input, 1: core completion.
- core_bin_data_out, input, NUM_INPUTS*DATA_WIDTH: core result.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, NUM_INPUTS*DATA_WIDTH: captured result.
- out_cycles, output, CYC_WIDTH: number of cycles core_en was high.
- out_truncated, output, 1: operation ended without core_op_finished.
- out_overflow, output, 1: operation ended by counter saturation.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state returns to IDLE.
  - out_valid, out_data, out_cycles, out_truncated, out_overflow, core_en, core_data and cnt all go to 0.
  - core_rst goes to 1.
  - in_ready is 0 while rst is low.
  - Reset mid-operation discards the operation; no output is produced.
- IDLE:
  - in_ready=1, core_rst=1, core_en=0.
  - On in_valid&&in_ready: latch in_data into core_data, latch limit_en/cycle_limit, clear cnt, go to CLEAR.
- CLEAR (exactly 1 cycle): core_rst=1, core_en=0, in_ready=0; go to RUN.
- RUN:
  - core_rst=0, core_en=1.
  - cnt holds the number of completed RUN cycles; the current cycle is number cnt+1.
  - At each edge, evaluate:
    - fin = core_op_finished
    - lim = limit_en && cycle_limit!=0 && cnt+1==cycle_limit
    - sat = cnt+1 == all-ones
  - If fin||lim||sat: out_cycles<=cnt+1, out_truncated<=!fin, out_overflow<=sat&&!fin&&!lim, go to CAPTURE.
  - Otherwise cnt<=cnt+1.
  - fin takes precedence; lim takes precedence over sat.
- CAPTURE (1 cycle):
  - core_en=0, core_rst=0, so the core holds its output.
  - out_data<=core_bin_data_out, out_valid<=1, go to OUT.
- OUT:
  - out_valid=1, core_en=0, core_rst=0, in_ready=0.
  - out_data, out_cycles and the flags are held stable until out_valid&&out_ready.
  - On that handshake: out_valid<=0, go to IDLE.
  - in_valid in any non-IDLE state is ignored and not accepted.
- Latency:
  - Accept at edge T gives CLEAR in cycle T+1.
  - First core_en cycle is T+2.
  - With N RUN cycles, out_valid rises at edge T+N+3.
- Throughput: one operation in flight. Back-to-back minimum gap is 1 IDLE cycle after the output handshake.
- Bit flips: core_en and core_rst are registered outputs, one flip per state transition, no glitches.

Test Plan:
1. DATA_WIDTH=8, NUM_INPUTS=2; in_data={8'd5,8'd3}; core model asserts op_finished on RUN cycle 20 with result 15 -> core_en high exactly 20 cycles, out_data=15, out_cycles=20, out_truncated=0, out_overflow=0, out_valid at accept+23.
2. limit_en=1, cycle_limit=10; core never finishes -> core_en high exactly 10 cycles, out_cycles=10, out_truncated=1, out_overflow=0.
3. limit_en=1, cycle_limit=10; op_finished on RUN cycle 10 -> out_cycles=10, out_truncated=0.
4. out_ready held low 5 cycles after out_valid; in_valid pulsed meanwhile -> out_valid, out_data and out_cycles stable, in_ready=0, second operand set not accepted until after the handshake plus 1 cycle.
5. rst driven low at RUN cycle 7 for 1 cycle -> next edge: core_en=0, core_rst=1, out_valid=0; in_ready=1 after rst high; the following operation with limit 5 reports out_cycles=5.
6. CYC_WIDTH=4, limit_en=0, no finish -> out_cycles=15, out_truncated=1, out_overflow=1; cycle_limit=0 with limit_en=1 behaves identically.
